// File: rtl/store_queue_pkg.sv
// Shared types, widths and encodings for the store queue and its drain engine.
package store_queue_pkg;

  localparam int SQ_DEPTH     = 8;
  localparam int XLEN         = 32;
  localparam int WIDTH_B_MASK = 4;
  localparam int ALU_NUM      = 3;
  localparam int N_WAY        = 2;

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RT_W  = $clog2(N_WAY) + 1;
  localparam int BN_W  = $clog2(WIDTH_B_MASK);

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef struct packed {
    logic                    valid;
    logic                    committed;
    logic [XLEN-1:0]         addr;
    logic [XLEN-1:0]         data;
    logic [1:0]              size;
    logic [WIDTH_B_MASK-1:0] b_mask;
  } sq_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sq_state_t;

  function automatic logic [CNT_W-1:0] count_ones(input logic [SQ_DEPTH-1:0] vec);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < SQ_DEPTH; i++) begin
      n = n + CNT_W'(vec[i]);
    end
    return n;
  endfunction

  function automatic logic size_legal(input logic [1:0] sz);
    return (sz == MEM_SIZE_BYTE) || (sz == MEM_SIZE_HALF) || (sz == MEM_SIZE_WORD);
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Store-issue capture bundle plus the memory write request/ack port.
interface store_queue_if;
  import store_queue_pkg::*;

  logic                    st_valid_in;
  logic [XLEN-1:0]         st_addr_in;
  logic [XLEN-1:0]         st_data_in;
  logic [1:0]              st_size_in;
  logic [WIDTH_B_MASK-1:0] st_b_mask_in;
  logic                    stop_is_st_en;
  logic                    mem_req_out;
  logic [XLEN-1:0]         mem_addr_out;
  logic [XLEN-1:0]         mem_data_out;
  logic [1:0]              mem_size_out;
  logic                    mem_ack_in;

  modport slave (
    input  st_valid_in, st_addr_in, st_data_in, st_size_in, st_b_mask_in, mem_ack_in,
    output stop_is_st_en, mem_req_out, mem_addr_out, mem_data_out, mem_size_out
  );

  modport master (
    output st_valid_in, st_addr_in, st_data_in, st_size_in, st_b_mask_in, mem_ack_in,
    input  stop_is_st_en, mem_req_out, mem_addr_out, mem_data_out, mem_size_out
  );

endinterface

// File: rtl/sq_drain_fsm.sv
// Drains the committed head store: one-cycle request, then hold until acknowledged.
module sq_drain_fsm
  import store_queue_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            head_ready,
  input  logic [XLEN-1:0] head_addr,
  input  logic [XLEN-1:0] head_data,
  input  logic [1:0]      head_size,
  input  logic            mem_ack_in,
  output logic            pop,
  output logic            mem_req_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [1:0]      mem_size_out
);

  sq_state_t       state_r;
  sq_state_t       state_nx_s;
  logic            req_nx_s;
  logic [XLEN-1:0] addr_nx_s;
  logic [XLEN-1:0] data_nx_s;
  logic [1:0]      size_nx_s;

  // Next state and next values of the registered memory outputs.
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = 1'b0;
    addr_nx_s  = mem_addr_out;
    data_nx_s  = mem_data_out;
    size_nx_s  = mem_size_out;
    pop        = 1'b0;
    case (state_r)
      IDLE: begin
        if (head_ready) begin
          state_nx_s = SEND;
          req_nx_s   = 1'b1;
          addr_nx_s  = head_addr;
          data_nx_s  = head_data;
          size_nx_s  = head_size;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SEND: begin
        state_nx_s = WAIT;
      end
      WAIT: begin
        // Acks seen in any other state fall through untouched.
        if (mem_ack_in) begin
          pop        = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and memory output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      mem_req_out  <= 1'b0;
      mem_addr_out <= {XLEN{1'b0}};
      mem_data_out <= {XLEN{1'b0}};
      mem_size_out <= 2'd0;
    end else begin
      state_r      <= state_nx_s;
      mem_req_out  <= req_nx_s;
      mem_addr_out <= addr_nx_s;
      mem_data_out <= data_nx_s;
      mem_size_out <= size_nx_s;
    end
  end

endmodule

// File: rtl/store_queue_checker.sv
// Protocol checks on the store queue inputs: no enqueue while full, legal sizes, no over-retire.
module store_queue_checker
  import store_queue_pkg::*;
(
  input logic             clock,
  input logic             reset,
  input logic             st_valid_in,
  input logic [1:0]       st_size_in,
  input logic             sq_full,
  input logic [RT_W-1:0]  rt_st_num_in,
  input logic [CNT_W-1:0] uncommitted
);

  a_no_enq_when_full: assert property (@(posedge clock) disable iff (reset)
    !(st_valid_in && sq_full));

  a_legal_size: assert property (@(posedge clock) disable iff (reset)
    st_valid_in |-> size_legal(st_size_in));

  a_no_over_retire: assert property (@(posedge clock) disable iff (reset)
    CNT_W'(rt_st_num_in) <= uncommitted);

endmodule

// File: rtl/store_queue.sv
// In-order circular store queue: speculative capture, branch squash/clear, retire, drain.
module store_queue
  import store_queue_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  store_queue_if.slave                   sq_if,
  input  logic [RT_W-1:0]                rt_st_num_in,
  input  logic                           clean_brat_en,
  input  logic [BN_W-1:0]                clean_brat_num,
  input  logic [ALU_NUM-1:0]             clean_bit_brat_en,
  input  logic [ALU_NUM-1:0][BN_W-1:0]   clean_bit_num_brat_ex,
  output logic                           sq_empty_out,
  output logic [CNT_W-1:0]               sq_count_out
);

  sq_entry_t               entries_r    [SQ_DEPTH];
  sq_entry_t               entries_nx_s [SQ_DEPTH];
  sq_entry_t               in_entry_s;
  logic [PTR_W-1:0]        head_r, tail_r, commit_r;
  logic [PTR_W-1:0]        tail_sq_s;
  logic [CNT_W-1:0]        count_r, count_nx_s, squash_num_s, uncommitted_s;
  logic [SQ_DEPTH-1:0]     squash_hit_s, uncommitted_vec_s;
  logic [WIDTH_B_MASK-1:0] clear_mask_s;
  logic                    full_s, in_drop_s, enq_s, pop_s, head_ready_s;
  logic                    mem_req_s;
  logic [XLEN-1:0]         mem_addr_s, mem_data_s;
  logic [1:0]              mem_size_s;

  assign full_s              = (count_r == CNT_W'(SQ_DEPTH));
  assign sq_if.stop_is_st_en = full_s;
  assign sq_empty_out        = (count_r == {CNT_W{1'b0}});
  assign sq_count_out        = count_r;
  assign head_ready_s        = entries_r[head_r].valid & entries_r[head_r].committed;

  // Union of branch bits resolved as correctly predicted this cycle.
  always_comb begin
    clear_mask_s = {WIDTH_B_MASK{1'b0}};
    for (int j = 0; j < ALU_NUM; j++) begin
      clear_mask_s[clean_bit_num_brat_ex[j]] = clear_mask_s[clean_bit_num_brat_ex[j]] | clean_bit_brat_en[j];
    end
  end

  // Squashed entries are the youngest contiguous run, so tail steps back by their number.
  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      uncommitted_vec_s[i] = entries_r[i].valid & ~entries_r[i].committed;
      squash_hit_s[i]      = clean_brat_en & uncommitted_vec_s[i] & entries_r[i].b_mask[clean_brat_num];
    end
  end

  assign squash_num_s  = count_ones(squash_hit_s);
  assign uncommitted_s = count_ones(uncommitted_vec_s);
  assign tail_sq_s     = tail_r - squash_num_s[PTR_W-1:0];
  assign in_drop_s     = clean_brat_en & sq_if.st_b_mask_in[clean_brat_num];
  assign enq_s         = sq_if.st_valid_in & ~full_s & ~in_drop_s;
  assign in_entry_s    = '{valid: 1'b1, committed: 1'b0, addr: sq_if.st_addr_in, data: sq_if.st_data_in,
                           size: sq_if.st_size_in, b_mask: sq_if.st_b_mask_in & ~clear_mask_s};
  assign count_nx_s    = count_r - squash_num_s + CNT_W'(enq_s) - CNT_W'(pop_s);

  // Next entry contents: squash, mask clear, retire, drain pop, then enqueue.
  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      entries_nx_s[i] = entries_r[i];
      if (squash_hit_s[i]) begin
        entries_nx_s[i] = '0;
      end else begin
        entries_nx_s[i].b_mask = entries_r[i].b_mask & ~clear_mask_s;
      end
    end
    for (int k = 0; k < N_WAY; k++) begin
      entries_nx_s[commit_r + PTR_W'(k)].committed =
        entries_nx_s[commit_r + PTR_W'(k)].committed | (RT_W'(k) < rt_st_num_in);
    end
    if (pop_s) begin
      entries_nx_s[head_r] = '0;
    end else begin
      entries_nx_s[head_r] = entries_nx_s[head_r];
    end
    if (enq_s) begin
      entries_nx_s[tail_sq_s] = in_entry_s;
    end else begin
      entries_nx_s[tail_sq_s] = entries_nx_s[tail_sq_s];
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      commit_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < SQ_DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      head_r    <= head_r + PTR_W'(pop_s);
      tail_r    <= tail_sq_s + PTR_W'(enq_s);
      commit_r  <= commit_r + PTR_W'(rt_st_num_in);
      count_r   <= count_nx_s;
      entries_r <= entries_nx_s;
    end
  end

  sq_drain_fsm u_drain (
    .clock        (clock),
    .reset        (reset),
    .head_ready   (head_ready_s),
    .head_addr    (entries_r[head_r].addr),
    .head_data    (entries_r[head_r].data),
    .head_size    (entries_r[head_r].size),
    .mem_ack_in   (sq_if.mem_ack_in),
    .pop          (pop_s),
    .mem_req_out  (mem_req_s),
    .mem_addr_out (mem_addr_s),
    .mem_data_out (mem_data_s),
    .mem_size_out (mem_size_s)
  );

  assign sq_if.mem_req_out  = mem_req_s;
  assign sq_if.mem_addr_out = mem_addr_s;
  assign sq_if.mem_data_out = mem_data_s;
  assign sq_if.mem_size_out = mem_size_s;

  store_queue_checker u_checker (
    .clock        (clock),
    .reset        (reset),
    .st_valid_in  (sq_if.st_valid_in),
    .st_size_in   (sq_if.st_size_in),
    .sq_full      (full_s),
    .rt_st_num_in (rt_st_num_in),
    .uncommitted  (uncommitted_s)
  );

endmodule
